// File: rtl/hazard_if.sv
// Hazard unit bundle: ID/EX pipeline observations in, stall/flush/forward controls out.
interface hazard_if;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic [4:0]  ex_rs1_addr;
  logic [4:0]  ex_rs2_addr;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic [1:0]  ex_Result_Src;
  logic        ex_redirect;
  logic        stall_pc;
  logic        stall_ifid;
  logic        flush_ifid;
  logic        flush_idex;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  // Pipeline side: supplies register-field observations, consumes controls.
  modport master (
    output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
    output ex_rs1_addr, ex_rs2_addr, ex_rd, ex_reg_write, ex_Result_Src, ex_redirect,
    input  stall_pc, stall_ifid, flush_ifid, flush_idex, fwd_a, fwd_b, stall_cnt, flush_cnt
  );

  // Hazard unit side.
  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
    input  ex_rs1_addr, ex_rs2_addr, ex_rd, ex_reg_write, ex_Result_Src, ex_redirect,
    output stall_pc, stall_ifid, flush_ifid, flush_idex, fwd_a, fwd_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_unit.sv
// Five-stage pipeline hazard unit: load-use stall, redirect flush, EX operand forwarding
// from shadowed MEM/WB destinations, and saturating stall/flush event counters.
module hazard_unit (
  input logic     clk,
  input logic     rst,
  hazard_if.slave bus
);

  typedef enum logic [1:0] {StRun, StStall, StRedir} state_e;

  localparam logic [1:0]  ResLoad = 2'b01;
  localparam logic [15:0] CntMax  = 16'hFFFF;

  state_e      state_q, state_d;
  logic [4:0]  mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic        mem_ld_q, mem_ld_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_wr_q, wb_wr_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic redir_acc;
  logic lu;
  logic lu_stall;
  logic flush_idex;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] m_rd, input logic m_wr,
                                         input logic m_ld,
                                         input logic [4:0] w_rd, input logic w_wr);
    logic [1:0] sel;
    sel = 2'b00;
    // A load in MEM has no data yet; the load-use stall covers that case.
    if (m_wr && (m_rd != 5'd0) && (m_rd == rs) && !m_ld) begin
      sel = 2'b10;
    end else if (w_wr && (w_rd != 5'd0) && (w_rd == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    redir_acc = bus.ex_redirect && (state_q != StRedir);
    lu = (bus.ex_Result_Src == ResLoad) && bus.ex_reg_write && (bus.ex_rd != 5'd0) &&
         ((bus.id_uses_rs1 && (bus.ex_rd == bus.id_rs1_addr)) ||
          (bus.id_uses_rs2 && (bus.ex_rd == bus.id_rs2_addr)));
    // Redirect wins; the stalled ID instruction is on the wrong path anyway.
    lu_stall = lu && (state_q == StRun) && !redir_acc;
  end

  always_comb begin
    bus.stall_pc   = 1'b0;
    bus.stall_ifid = 1'b0;
    bus.flush_ifid = 1'b0;
    flush_idex     = 1'b1;
    bus.fwd_a      = 2'b00;
    bus.fwd_b      = 2'b00;
    if (!rst) begin
      bus.stall_pc   = lu_stall;
      bus.stall_ifid = lu_stall;
      bus.flush_ifid = redir_acc;
      flush_idex     = redir_acc || lu_stall;
      bus.fwd_a      = fwd_sel(bus.ex_rs1_addr, mem_rd_q, mem_wr_q, mem_ld_q, wb_rd_q, wb_wr_q);
      bus.fwd_b      = fwd_sel(bus.ex_rs2_addr, mem_rd_q, mem_wr_q, mem_ld_q, wb_rd_q, wb_wr_q);
    end
    bus.flush_idex = flush_idex;
    bus.stall_cnt  = stall_cnt_q;
    bus.flush_cnt  = flush_cnt_q;
  end

  always_comb begin
    state_d     = StRun;
    mem_rd_d    = 5'd0;
    mem_wr_d    = 1'b0;
    mem_ld_d    = 1'b0;
    wb_rd_d     = mem_rd_q;
    wb_wr_d     = mem_wr_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (!flush_idex) begin
      mem_rd_d = bus.ex_rd;
      mem_wr_d = bus.ex_reg_write;
      mem_ld_d = (bus.ex_Result_Src == ResLoad);
    end

    unique case (state_q)
      StRun, StStall, StRedir: begin
        if (redir_acc) begin
          state_d = StRedir;
        end else if (lu_stall) begin
          state_d = StStall;
        end else begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase

    if (lu_stall && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (redir_acc && (flush_cnt_q != CntMax)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      mem_rd_q    <= 5'd0;
      mem_wr_q    <= 1'b0;
      mem_ld_q    <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_wr_q     <= 1'b0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_ld_q    <= mem_ld_d;
      wb_rd_q     <= wb_rd_d;
      wb_wr_q     <= wb_wr_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed plus randomized checks of hazard_unit against a cycle-level behavioural model.
module tb_hazard_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_if bus ();

  hazard_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } shadow_t;

  // Model state: last cycle's event and the two older instructions' destinations.
  shadow_t     m_mem, m_wb;
  bit          m_prev_stall, m_prev_redir;
  int unsigned m_scnt, m_fcnt;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (m_mem.wr && m_mem.rd != 0 && m_mem.rd == rs && !m_mem.ld) return 2'b10;
    if (m_wb.wr && m_wb.rd != 0 && m_wb.rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Called just after a negedge with inputs already applied; checks, then crosses posedge.
  task automatic step();
    bit acc, lu, stl, fl_idex;
    logic [1:0] fa, fb;
    #1;
    acc = bus.ex_redirect && !m_prev_redir;
    lu  = bus.ex_Result_Src == 2'b01 && bus.ex_reg_write && bus.ex_rd != 0 &&
          ((bus.id_uses_rs1 && bus.ex_rd == bus.id_rs1_addr) ||
           (bus.id_uses_rs2 && bus.ex_rd == bus.id_rs2_addr));
    stl = lu && !m_prev_stall && !m_prev_redir && !acc;
    fa  = m_fwd(bus.ex_rs1_addr);
    fb  = m_fwd(bus.ex_rs2_addr);
    fl_idex = acc || stl;
    if (rst) begin
      acc = 0; stl = 0; fa = 0; fb = 0; fl_idex = 1;
    end
    vectors++;
    chk("stall_pc",   16'(bus.stall_pc),   16'(stl));
    chk("stall_ifid", 16'(bus.stall_ifid), 16'(stl));
    chk("flush_ifid", 16'(bus.flush_ifid), 16'(acc));
    chk("flush_idex", 16'(bus.flush_idex), 16'(fl_idex));
    chk("fwd_a",      16'(bus.fwd_a),      16'(fa));
    chk("fwd_b",      16'(bus.fwd_b),      16'(fb));
    chk("stall_cnt",  bus.stall_cnt,       16'(m_scnt));
    chk("flush_cnt",  bus.flush_cnt,       16'(m_fcnt));
    @(posedge clk);
    if (rst) begin
      m_mem = '0; m_wb = '0; m_prev_stall = 0; m_prev_redir = 0; m_scnt = 0; m_fcnt = 0;
    end else begin
      m_wb = m_mem;
      m_mem = fl_idex ? '0 : '{rd: bus.ex_rd, wr: bus.ex_reg_write,
                               ld: bus.ex_Result_Src == 2'b01};
      m_prev_stall = stl;
      m_prev_redir = acc;
      if (stl && m_scnt < 32'hFFFF) m_scnt++;
      if (acc && m_fcnt < 32'hFFFF) m_fcnt++;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    bus.id_rs1_addr = 0; bus.id_rs2_addr = 0; bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0;
    bus.ex_rs1_addr = 0; bus.ex_rs2_addr = 0; bus.ex_rd = 0; bus.ex_reg_write = 0;
    bus.ex_Result_Src = 2'b00; bus.ex_redirect = 0;
  endtask

  task automatic set_ex(input logic [4:0] rd, input logic wr, input logic [1:0] src,
                        input logic [4:0] rs1, input logic [4:0] rs2);
    bus.ex_rd = rd; bus.ex_reg_write = wr; bus.ex_Result_Src = src;
    bus.ex_rs1_addr = rs1; bus.ex_rs2_addr = rs2;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                        input logic u2);
    bus.id_rs1_addr = rs1; bus.id_uses_rs1 = u1; bus.id_rs2_addr = rs2; bus.id_uses_rs2 = u2;
  endtask

  initial begin
    m_mem = '0; m_wb = '0; m_prev_stall = 0; m_prev_redir = 0; m_scnt = 0; m_fcnt = 0;
    idle();
    @(negedge clk);

    // Reset: forced outputs while rst is high.
    rst = 1; step(); step();
    rst = 0;

    // Load-use: EX lw x5, ID add x6,x5,x1.
    set_ex(5, 1, 2'b01, 0, 0); set_id(5, 1, 1, 1);
    #1; chk("lu_stall_pc", 16'(bus.stall_pc), 16'd1);
    step();
    chk("lu_stall_cnt", bus.stall_cnt, 16'd1);
    set_ex(6, 1, 2'b00, 5, 1); set_id(0, 0, 0, 0);
    step();
    step();

    // ALU back-to-back: add x7 then sub x8,x7,x7.
    set_ex(7, 1, 2'b00, 1, 2); step();
    set_ex(8, 1, 2'b00, 7, 7);
    #1; chk("b2b_fwd_a", 16'(bus.fwd_a), 16'(2'b10));
    chk("b2b_fwd_b", 16'(bus.fwd_b), 16'(2'b10));
    chk("b2b_no_stall", 16'(bus.stall_pc), 16'd0);
    step();
    idle(); step(); step();

    // x0 load and unused-source match: no stall.
    set_ex(0, 1, 2'b01, 0, 0); set_id(0, 1, 0, 1); step();
    set_ex(9, 1, 2'b01, 0, 0); set_id(9, 0, 3, 1);
    #1; chk("unused_no_stall", 16'(bus.stall_pc), 16'd0);
    step();
    idle(); step(); step();

    // Redirect together with load-use: flush only.
    set_ex(5, 1, 2'b01, 0, 0); set_id(5, 1, 0, 0); bus.ex_redirect = 1;
    #1; chk("both_stall_pc", 16'(bus.stall_pc), 16'd0);
    chk("both_flush_ifid", 16'(bus.flush_ifid), 16'd1);
    step();
    idle();
    step();

    // Redirect held three cycles: accepted, ignored, accepted.
    bus.ex_redirect = 1;
    step();
    #1; chk("redir2_ignored", 16'(bus.flush_ifid), 16'd0);
    step();
    #1; chk("redir3_accepted", 16'(bus.flush_ifid), 16'd1);
    step();
    idle(); step();

    // Randomized traffic on a small register window to provoke matches.
    for (int i = 0; i < 400; i++) begin
      bus.ex_rd         = 5'($urandom_range(0, 3));
      bus.ex_reg_write  = 1'($urandom_range(0, 3) != 0);
      bus.ex_Result_Src = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'($urandom_range(0, 3));
      bus.ex_rs1_addr   = 5'($urandom_range(0, 3));
      bus.ex_rs2_addr   = 5'($urandom_range(0, 3));
      bus.id_rs1_addr   = 5'($urandom_range(0, 3));
      bus.id_rs2_addr   = 5'($urandom_range(0, 3));
      bus.id_uses_rs1   = 1'($urandom_range(0, 1));
      bus.id_uses_rs2   = 1'($urandom_range(0, 1));
      bus.ex_redirect   = ($urandom_range(0, 5) == 0);
      rst               = ($urandom_range(0, 60) == 0);
      step();
    end
    rst = 0; idle(); step(); step();

    // Saturation: preload stall counter, then three stalls.
    force dut.stall_cnt_q = 16'hFFFE;
    @(posedge clk);
    #1 release dut.stall_cnt_q;
    @(negedge clk);
    m_scnt = 32'hFFFE;
    set_ex(4, 1, 2'b01, 0, 0); set_id(2, 1, 4, 1);
    for (int i = 0; i < 6; i++) step();
    chk("sat_stall_cnt", bus.stall_cnt, 16'hFFFF);
    idle();

    // Reset mid-stall aborts it and clears counters.
    set_ex(4, 1, 2'b01, 0, 0); set_id(4, 1, 0, 0);
    step();
    rst = 1; step();
    rst = 0;
    chk("rst_stall_cnt", bus.stall_cnt, 16'd0);
    chk("rst_flush_cnt", bus.flush_cnt, 16'd0);
    #1; chk("rst_run_stalls_again", 16'(bus.stall_pc), 16'd1);
    step();
    idle(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
